// File: rtl/lcd_text_writer.sv
`timescale 1ns/1ps
// HD44780 8-bit character writer: valid/ready character input, RS/RW/E bus cycles, cursor tracking.
// Optional LCD_AUTO_WRAP_EN: a printable write at column 15 queues a set-DDRAM command to the next row.
module lcd_text_writer #(
    parameter int SETUP_CYCLES      = 3,
    parameter int E_HIGH_CYCLES     = 12,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_complete_flag,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       busy,
    output logic       RS_write_lcd,
    output logic       RW_write_lcd,
    output logic       E_write_lcd,
    output logic [7:0] data_write_lcd,
    output logic [3:0] cursor_col,
    output logic       cursor_row
);

    localparam int MAX_A   = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
    localparam int MAX_B   = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             rs_q;
    logic             e_q;
    logic [7:0]       data_q;
    logic [3:0]       col_q;
    logic             row_q;
    logic             clear_q;
    logic             pend_q;
    logic [7:0]       pend_data_q;

    logic             accept;
    logic [CNT_W-1:0] wait_last;

    assign accept    = (state_q == ST_IDLE) && ready_q && char_valid;
    assign wait_last = clear_q ? CLEAR_LAST : CMD_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            data_q      <= 8'h00;
            col_q       <= 4'd0;
            row_q       <= 1'b0;
            clear_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
        end else begin
            case (state_q)
                ST_WAIT_INIT: begin
                    if (init_complete_flag) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_SETUP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (char_data == 8'h0C) begin
                            rs_q    <= 1'b0;
                            data_q  <= 8'h01;
                            clear_q <= 1'b1;
                            col_q   <= 4'd0;
                            row_q   <= 1'b0;
                        end else if (char_data == 8'h0A) begin
                            // Set-DDRAM address: row 1 starts at 0x40.
                            rs_q    <= 1'b0;
                            data_q  <= {1'b1, ~row_q, 6'b000000};
                            clear_q <= 1'b0;
                            col_q   <= 4'd0;
                            row_q   <= ~row_q;
                        end else begin
                            rs_q    <= 1'b1;
                            data_q  <= char_data;
                            clear_q <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
                            if (col_q == 4'd15) begin
                                col_q       <= 4'd0;
                                row_q       <= ~row_q;
                                pend_q      <= 1'b1;
                                pend_data_q <= {1'b1, ~row_q, 6'b000000};
                            end else begin
                                col_q <= col_q + 4'd1;
                            end
`else
                            col_q <= col_q + 4'd1;
`endif
                        end
                    end else if (!init_complete_flag) begin
                        state_q <= ST_WAIT_INIT;
                        ready_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == EHIGH_LAST) begin
                        cnt_q   <= '0;
                        e_q     <= 1'b0;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == wait_last) begin
                        cnt_q <= '0;
                        // A queued wrap command goes out back-to-back before returning to IDLE.
                        if (pend_q) begin
                            pend_q  <= 1'b0;
                            rs_q    <= 1'b0;
                            data_q  <= pend_data_q;
                            clear_q <= 1'b0;
                            state_q <= ST_SETUP;
                        end else begin
                            busy_q <= 1'b0;
                            if (init_complete_flag) begin
                                state_q <= ST_IDLE;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT_INIT;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_WAIT_INIT;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    e_q     <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready     = ready_q;
    assign busy           = busy_q;
    assign RS_write_lcd   = rs_q;
    assign RW_write_lcd   = 1'b0;
    assign E_write_lcd    = e_q;
    assign data_write_lcd = data_q;
    assign cursor_col     = col_q;
    assign cursor_row     = row_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
`timescale 1ns/1ps
// Directed bench for lcd_text_writer: bus-cycle scoreboard, handshake timing, cursor, wrap and reset.
module tb_lcd_text_writer;

    localparam int S  = 2;
    localparam int EH = 4;
    localparam int CW = 10;
    localparam int CL = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       init_complete_flag = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready, busy, RS_write_lcd, RW_write_lcd, E_write_lcd;
    logic [7:0] data_write_lcd;
    logic [3:0] cursor_col;
    logic       cursor_row;

    lcd_text_writer #(
        .SETUP_CYCLES(S), .E_HIGH_CYCLES(EH), .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_complete_flag(init_complete_flag),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready), .busy(busy),
        .RS_write_lcd(RS_write_lcd), .RW_write_lcd(RW_write_lcd), .E_write_lcd(E_write_lcd),
        .data_write_lcd(data_write_lcd), .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } bus_t;

    bus_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         rise_cnt = 0;
    logic [3:0] m_col = 4'd0;
    logic       m_row = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: each E rise is one LCD write, compared against the scoreboard.
    logic e_prev = 1'b0;
    int   e_len  = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            e_prev = 1'b0;
            e_len  = 0;
        end else begin
            if (E_write_lcd && !e_prev) begin
                bus_t t;
                rise_cnt++;
                check("sb_nonempty_at_E", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    check("bus_rs", RS_write_lcd, t.rs);
                    check("bus_data", data_write_lcd, t.data);
                    check("bus_rw", RW_write_lcd, 0);
                end
                $display("bus write rs=%0d data=0x%02h", RS_write_lcd, data_write_lcd);
                e_len = 1;
            end else if (E_write_lcd) begin
                e_len++;
            end else if (e_prev) begin
                check("e_width", e_len, EH);
            end
            e_prev = E_write_lcd;
        end
    end

    task automatic push_model(input logic [7:0] code, output bus_t first);
        bus_t b;
        logic wrap_cmd;
        wrap_cmd = 1'b0;
        if (code == 8'h0C) begin
            b.rs = 1'b0; b.data = 8'h01; m_col = 4'd0; m_row = 1'b0;
        end else if (code == 8'h0A) begin
            b.rs = 1'b0; b.data = m_row ? 8'h80 : 8'hC0; m_row = ~m_row; m_col = 4'd0;
        end else begin
            b.rs = 1'b1; b.data = code;
            if (m_col == 4'd15) begin
                m_col = 4'd0;
`ifdef LCD_AUTO_WRAP_EN
                wrap_cmd = 1'b1;
`endif
            end else begin
                m_col = m_col + 4'd1;
            end
        end
        exp_q.push_back(b);
        if (wrap_cmd) begin
            bus_t w;
            w.rs = 1'b0; w.data = m_row ? 8'h80 : 8'hC0;
            exp_q.push_back(w);
            m_row = ~m_row;
        end
        first = b;
    endtask

    task automatic wait_ready(input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check("ready_timeout", char_ready, 1);
    endtask

    task automatic send(input logic [7:0] code);
        bus_t f;
        wait_ready(200);
        push_model(code, f);
        char_valid = 1'b1;
        char_data  = code;
        @(posedge clk);
        #1 char_valid = 1'b0;
        $display("accept char 0x%02h", code);
    endtask

    // Accept one character and check the cycle-by-cycle handshake and E timing.
    task automatic send_timed(input logic [7:0] code, input int exp_rdy);
        bus_t f;
        wait_ready(200);
        push_model(code, f);
        char_valid = 1'b1;
        char_data  = code;
        @(posedge clk);
        #1 char_valid = 1'b0;
        for (int k = 1; k <= exp_rdy; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("t1_rs", RS_write_lcd, f.rs);
                check("t1_data", data_write_lcd, f.data);
            end
            check("e_timing", E_write_lcd, (k >= 1 + S && k <= S + EH));
            check("ready_timing", char_ready, (k == exp_rdy));
            check("busy_timing", busy, (k < exp_rdy));
        end
        check("cursor_col", cursor_col, m_col);
        check("cursor_row", cursor_row, m_row);
        $display("timed txn char 0x%02h col=%0d row=%0d", code, cursor_col, cursor_row);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", char_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rs", RS_write_lcd, 0);
        check("rst_rw", RW_write_lcd, 0);
        check("rst_e", E_write_lcd, 0);
        check("rst_data", data_write_lcd, 8'h00);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        reset_n = 1'b1;

        // No handshake before init completes
        char_valid = 1'b1;
        char_data  = 8'h41;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 4) check("noinit_ready", char_ready, 0);
        end
        char_valid = 1'b0;
        check("noinit_no_e", rise_cnt, 0);

        init_complete_flag = 1'b1;
        send_timed(8'h41, 1 + S + EH + CW);
        send_timed(8'h0C, 1 + S + EH + CL);
        send_timed(8'h0A, 1 + S + EH + CW);

        // Sixteen printable characters from home position
        send(8'h0C);
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
        wait_ready(200);
        check("line_col", cursor_col, m_col);
        check("line_row", cursor_row, m_row);
        check("sb_drained", exp_q.size(), 0);
        $display("16-char line done col=%0d row=%0d", cursor_col, cursor_row);

        // init flag falls mid-transaction: finishes, then stays not-ready
        send(8'h43);
        @(negedge clk);
        init_complete_flag = 1'b0;
        repeat (S + EH + CW + 5) @(negedge clk);
        check("flagdrop_busy", busy, 0);
        check("flagdrop_ready", char_ready, 0);
        check("flagdrop_col", cursor_col, m_col);
        init_complete_flag = 1'b1;
        @(negedge clk);
        check("flagrise_ready", char_ready, 1);
        $display("flag drop/raise handled");

        // Reset while E is high
        send(8'h42);
        n = 0;
        while (!E_write_lcd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("e_seen_before_reset", E_write_lcd, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_e", E_write_lcd, 0);
        check("arst_rs", RS_write_lcd, 0);
        check("arst_data", data_write_lcd, 8'h00);
        check("arst_busy", busy, 0);
        check("arst_ready", char_ready, 0);
        check("arst_col", cursor_col, 0);
        m_col = 4'd0;
        m_row = 1'b0;
        init_complete_flag = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_wait_init", char_ready, 0);
        init_complete_flag = 1'b1;
        @(negedge clk);
        check("post_rst_idle", char_ready, 1);
        $display("mid-pulse reset handled");

        send_timed(8'h44, 1 + S + EH + CW);
        check("final_sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
